// File: rtl/riscv_defines.sv
// Shared fetch-path definitions: word width, canonical NOP, fetch FSM encoding
// and the FIFO entry layout pairing an instruction with its PC.
package riscv_defines;

    localparam int WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] fetch_state_e;

    localparam fetch_state_e FS_BOOT  = 2'd0;
    localparam fetch_state_e FS_FETCH = 2'd1;
    localparam fetch_state_e FS_DRAIN = 2'd2;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic [WORD_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetched {instr, pc} entries. Flush wins over push/pop, and a
// push into a full FIFO is accepted only when the head is popped the same cycle.
module fetch_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front end: credit-limited word requests, in-order response
// buffering with PCs, and redirect handling that discards stale responses.
module instr_prefetch_unit
    import riscv_defines::*;
#(
    parameter int                    DEPTH     = 2,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic [WORD_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    output logic                  no_op_flag_o,
    input  logic                  instr_ready_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_target_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [WORD_WIDTH-1:0] fetch_addr_q;
    logic [WORD_WIDTH-1:0] held_addr_q;
    logic [WORD_WIDTH-1:0] resp_pc_q;
    logic [WORD_WIDTH-1:0] target;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         outstanding_d;
    logic [CW-1:0]         discard_q;
    logic [CW-1:0]         discard_d;
    logic [SW-1:0]         credit_sum;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  held_q;
    logic                  held_d;
    logic                  stale_held_q;
    logic                  stale_held_d;
    logic                  push;
    logic                  pop;
    logic                  gnt_ok;
    logic                  credit_ok;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;

    assign target = branch_target_i & ~WORD_WIDTH'(3);
    assign pop    = !fifo_empty && instr_ready_i && !branch_i;

    // Counting this cycle's pop as a freed slot is what lets DEPTH=2 stream one
    // instruction per cycle against a zero-wait memory.
    assign credit_sum = SW'(fifo_count) - SW'(pop) + SW'(outstanding_q);
    assign credit_ok  = (credit_sum < SW'(DEPTH)) && !(fifo_full && !pop);

    assign instr_req_o  = held_q || ((state_q != FS_BOOT) && !branch_i && credit_ok);
    assign instr_addr_o = stale_held_q ? held_addr_q : fetch_addr_q;

    assign gnt_ok     = instr_req_o && instr_gnt_i;
    assign held_d     = instr_req_o && !instr_gnt_i;
    assign push       = instr_rvalid_i && (discard_q == '0) && !branch_i;
    assign push_entry = '{instr: instr_rdata_i, pc: resp_pc_q};

    // A held request that survives a redirect is already counted in discard,
    // so its eventual grant must not advance the new fetch stream.
    always_comb begin
        outstanding_d = outstanding_q + CW'(gnt_ok) - CW'(instr_rvalid_i);

        stale_held_d = stale_held_q;
        if (branch_i) begin
            stale_held_d = held_d;
        end else if (gnt_ok) begin
            stale_held_d = 1'b0;
        end

        discard_d = discard_q;
        if (branch_i) begin
            discard_d = outstanding_d + CW'(held_d);
        end else if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        state_d = state_q;
        if (branch_i) begin
            state_d = ((outstanding_d != '0) || held_d) ? FS_DRAIN : FS_FETCH;
        end else begin
            case (state_q)
                FS_BOOT:  state_d = FS_FETCH;
                FS_FETCH: state_d = FS_FETCH;
                FS_DRAIN: begin
                    if ((discard_d == '0) && !stale_held_d) begin
                        state_d = FS_FETCH;
                    end
                end
                default:  state_d = FS_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= FS_BOOT;
            fetch_addr_q  <= BOOT_ADDR;
            held_addr_q   <= BOOT_ADDR;
            resp_pc_q     <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            held_q        <= 1'b0;
            stale_held_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            held_q        <= held_d;
            stale_held_q  <= stale_held_d;
            if (held_d) begin
                held_addr_q <= instr_addr_o;
            end
            if (branch_i) begin
                fetch_addr_q <= target;
            end else if (gnt_ok && !stale_held_q) begin
                fetch_addr_q <= fetch_addr_q + WORD_WIDTH'(4);
            end
            if (branch_i) begin
                resp_pc_q <= target;
            end else if (push) begin
                resp_pc_q <= resp_pc_q + WORD_WIDTH'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch_i),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // When empty, the PC output previews the next expected response address.
    assign instr_valid_o = !fifo_empty;
    assign no_op_flag_o  = fifo_empty;
    assign instruction_o = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc_o    = fifo_empty ? resp_pc_q : head.pc;

endmodule
